stack_mem_controller: RTL and testbench

- Multi-cycle data-memory controller in the MEM stage.
- Serves loads, stores and stack PUSH/POP from the decode control signals against a wait-stated synchronous SRAM.
- Owns the architectural stack pointer.
- Holds `ready` low to freeze the pipeline while an access is in flight.

---
 rtl/stack_mem_controller_if.sv | 36 +++
 rtl/stack_mem_controller.sv | 136 +++++++++++++
 tb/tb_stack_mem_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_mem_controller_if.sv
// +----------------------------------------------------------------------+
// | stack_mem_controller_if: MEM-stage request/response and SRAM port.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface stack_mem_controller_if #(
  parameter int ADDR_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic              push_en;
  logic              pop_en;
  logic [31:0]       alu_addr;
  logic [31:0]       st_val;
  logic              ready;
  logic [31:0]       rd_data;
  logic [31:0]       sp;
  logic              stk_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_we_n;
  logic [31:0]       sram_rdata;

  modport slave (
    input  mem_read, mem_write, push_en, pop_en, alu_addr, st_val, sram_rdata,
    output ready, rd_data, sp, stk_err, sram_addr, sram_wdata, sram_we_n
  );

  modport master (
    output mem_read, mem_write, push_en, pop_en, alu_addr, st_val, sram_rdata,
    input  ready, rd_data, sp, stk_err, sram_addr, sram_wdata, sram_we_n
  );
endinterface

`default_nettype wire

// File: rtl/stack_mem_controller.sv
// +----------------------------------------------------------------------+
// | stack_mem_controller: wait-stated SRAM load/store/PUSH/POP, owns SP.  |
// | Optional macro STACK_GUARD_EN: overflow/underflow guard with stk_err. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module stack_mem_controller #(
  parameter int          ADDR_W      = 16,
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] STACK_BASE  = 32'h0000_0800,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
  input  wire logic              clk,
  input  wire logic              rst,
  stack_mem_controller_if.slave  bus
);

  localparam logic [1:0]    S_IDLE     = 2'd0;
  localparam logic [1:0]    S_ACCESS   = 2'd1;
  localparam logic [1:0]    S_DONE     = 2'd2;
  localparam int            CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_sp;
  logic [31:0]       r_rd_data;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we_n;
  logic              r_is_wr;
  logic              r_push;
  logic              r_pop;
  logic              r_fault;

  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_fault;
  logic [31:0]       w_byte_addr;
  logic              w_last;
  logic              w_unused_bits;

  // Write wins when both strobes are up, so POP needs mem_write low.
  assign w_req       = bus.mem_read | bus.mem_write;
  assign w_push      = bus.mem_write & bus.push_en;
  assign w_pop       = bus.mem_read & bus.pop_en & ~bus.mem_write;
  assign w_byte_addr = w_push ? (r_sp - 32'd4) : (w_pop ? r_sp : bus.alu_addr);
  assign w_last      = (r_state == S_ACCESS) && (r_cnt == '0);
  assign w_unused_bits = ^{w_byte_addr[31:ADDR_W+2], w_byte_addr[1:0]};

`ifdef STACK_GUARD_EN
  logic r_err;

  assign w_fault = (w_push && (r_sp == STACK_LIMIT)) || (w_pop && (r_sp == STACK_BASE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_last && r_fault) begin
      r_err <= 1'b1;
    end
  end

  assign bus.stk_err = r_err;
`else
  logic w_unused_cfg;

  assign w_fault      = 1'b0;
  assign w_unused_cfg = ^STACK_LIMIT;
  assign bus.stk_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sp      <= STACK_BASE;
      r_rd_data <= 32'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_we_n    <= 1'b1;
      r_is_wr   <= 1'b0;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= w_byte_addr[ADDR_W+1:2];
            r_wdata <= bus.st_val;
            r_is_wr <= bus.mem_write;
            r_push  <= w_push;
            r_pop   <= w_pop;
            r_fault <= w_fault;
            r_cnt   <= C_CNT_INIT;
            r_we_n  <= ~(bus.mem_write & ~w_fault);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            if (!r_is_wr) begin
              r_rd_data <= r_fault ? 32'd0 : bus.sram_rdata;
            end
            if (!r_fault && r_push) begin
              r_sp <= r_sp - 32'd4;
            end else if (!r_fault && r_pop) begin
              r_sp <= r_sp + 32'd4;
            end
            r_we_n  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // Request inputs are still held here; they must not restart an access.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready      = (r_state == S_ACCESS) ? 1'b0 :
                          (r_state == S_IDLE)   ? ~w_req : 1'b1;
  assign bus.rd_data    = r_rd_data;
  assign bus.sp         = r_sp;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_wdata = r_wdata;
  assign bus.sram_we_n  = r_we_n;

endmodule

`default_nettype wire

// File: tb/tb_stack_mem_controller.sv
// +----------------------------------------------------------------------+
// | tb_stack_mem_controller: randomized bench with transaction-level model.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_stack_mem_controller;
  localparam int          ADDR_W = 16;
  localparam int          W      = 3;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_0800;
  localparam logic [31:0] LIMIT  = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_mem_controller_if #(.ADDR_W(ADDR_W)) bus();

  stack_mem_controller #(
    .ADDR_W(ADDR_W), .WAIT_CYCLES(W), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0]       sram_arr [0:DEPTH-1];
  logic [31:0]       m_mem    [0:DEPTH-1];
  logic [31:0]       m_sp, m_rd;
  logic              m_err;
  logic              chk_en, chk_bus, chk_wd, e_ready, e_we_n;
  logic [ADDR_W-1:0] e_addr, last_wa;
  logic [31:0]       e_wdata;
  int                checks, failures, n_rdy_lo, n_we_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // The SRAM itself: latches whatever the DUT writes.
  always @(posedge clk) begin
    if (bus.sram_we_n === 1'b0) sram_arr[bus.sram_addr] <= bus.sram_wdata;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(bus.ready), 32'(e_ready));
      chk("sram_we_n", 32'(bus.sram_we_n), 32'(e_we_n));
      chk("sp", bus.sp, m_sp);
      chk("rd_data", bus.rd_data, m_rd);
      chk("stk_err", 32'(bus.stk_err), 32'(m_err));
      if (chk_bus) chk("sram_addr", 32'(bus.sram_addr), 32'(e_addr));
      if (chk_wd)  chk("sram_wdata", bus.sram_wdata, e_wdata);
      if (!bus.ready)     n_rdy_lo++;
      if (!bus.sram_we_n) n_we_lo++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.push_en   = 1'($urandom);
      bus.pop_en    = 1'($urandom);
      bus.alu_addr  = $urandom;
      e_ready = 1'b1; e_we_n = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    end
  endtask

  // One complete access: sample cycle, W access cycles, DONE cycle.
  task automatic txn(input logic rd, input logic wr, input logic pe, input logic po,
                     input logic [31:0] a, input logic [31:0] d);
    logic push, pop, fault;
    logic [31:0] ba;
    logic [ADDR_W-1:0] wa;
    push  = wr & pe;
    pop   = rd & po & ~wr;
    ba    = push ? m_sp - 32'd4 : (pop ? m_sp : a);
    wa    = ba[ADDR_W+1:2];
    fault = 1'b0;
`ifdef STACK_GUARD_EN
    fault = (push && m_sp == LIMIT) || (pop && m_sp == BASE);
`endif
    cyc();
    bus.mem_read = rd; bus.mem_write = wr; bus.push_en = pe; bus.pop_en = po;
    bus.alu_addr = a;  bus.st_val = d;
    e_ready = 1'b0; e_we_n = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    for (int k = 1; k <= W; k++) begin
      cyc();
      e_we_n  = ~(wr & ~fault);
      chk_bus = ~fault; e_addr = wa;
      chk_wd  = wr & ~fault; e_wdata = d;
      bus.sram_rdata = (k == W) ? sram_arr[bus.sram_addr] : $urandom;
    end
    cyc();
    if (wr && !fault) m_mem[wa] = d;
    if (!wr) m_rd = fault ? 32'd0 : m_mem[wa];
    if (fault)     m_err = 1'b1;
    else if (push) m_sp = m_sp - 32'd4;
    else if (pop)  m_sp = m_sp + 32'd4;
    e_ready = 1'b1; e_we_n = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    last_wa = wa;
  endtask

  initial begin
    int r0, w0;
    logic rd, wr;
    logic [31:0] a;
    checks = 0; failures = 0; n_rdy_lo = 0; n_we_lo = 0;
    chk_en = 1'b0; chk_bus = 1'b0; chk_wd = 1'b0; e_ready = 1'b1; e_we_n = 1'b1;
    e_addr = '0; e_wdata = '0; last_wa = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_arr[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h1234_5678;
      m_mem[i]    = 32'(i) * 32'h9E37_79B9 ^ 32'h1234_5678;
    end
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.push_en = 1'b0; bus.pop_en = 1'b0;
    bus.alu_addr = '0; bus.st_val = '0; bus.sram_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_sp", bus.sp, 32'h800);
    chk("rst_rd", bus.rd_data, 32'd0);
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_wdata", bus.sram_wdata, 32'd0);
    chk("rst_err", 32'(bus.stk_err), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b0;
    m_sp = BASE; m_rd = 32'd0; m_err = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Directed: store then load back.
    r0 = n_rdy_lo; w0 = n_we_lo;
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("st_word", 32'(last_wa), 32'h4);
    chk("st_we_lo_cycles", 32'(n_we_lo - w0), 32'd3);
    chk("st_ready_lo_cycles", 32'(n_rdy_lo - r0), 32'd4);
    idle(1);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("ld_deadbeef", bus.rd_data, 32'hDEAD_BEEF);

    // Stack push/pop ordering.
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h11);
    chk("push1_word", 32'(last_wa), 32'h1FF);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h22);
    chk("push2_word", 32'(last_wa), 32'h1FE);
    chk("push2_sp", bus.sp, 32'h7F8);
    idle(1);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("pop1_rd", bus.rd_data, 32'h22);
    chk("pop1_sp", bus.sp, 32'h7FC);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("pop2_rd", bus.rd_data, 32'h11);
    chk("pop2_sp", bus.sp, 32'h800);

    // Read and write together: the write wins.
    txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFE_0001);
    chk("both_rd_kept", bus.rd_data, 32'h11);
    chk("both_sp", bus.sp, 32'h800);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("both_written", bus.rd_data, 32'hCAFE_0001);

    // Back-to-back loads held through DONE: exactly two accesses.
    idle(1);
    r0 = n_rdy_lo;
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    idle(2);
    chk("b2b_ready_lo_cycles", 32'(n_rdy_lo - r0), 32'd8);

`ifdef STACK_GUARD_EN
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("uf_rd", bus.rd_data, 32'd0);
    chk("uf_err", 32'(bus.stk_err), 32'd1);
    chk("uf_sp", bus.sp, 32'h800);
    for (int i = 0; i < 256; i++) txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'(i));
    chk("full_sp", bus.sp, 32'h400);
    w0 = n_we_lo;
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD0_BAD0);
    chk("of_no_write", 32'(n_we_lo - w0), 32'd0);
    chk("of_err", 32'(bus.stk_err), 32'd1);
    chk("of_sp", bus.sp, 32'h400);
`else
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("wrap_sp", bus.sp, 32'h804);
    chk("wrap_err", 32'(bus.stk_err), 32'd0);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h5A5A_0000);
    chk("wrap_back_sp", bus.sp, 32'h800);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      txn(rd, wr, 1'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    // Reset in the second access cycle of a PUSH.
    idle(1);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h7777_0000);
    cyc();
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.push_en = 1'b1; bus.pop_en = 1'b0;
    bus.st_val = 32'h3333_0000;
    e_ready = 1'b0; e_we_n = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    last_wa = 16'((m_sp - 32'd4) >> 2);
    cyc();
    e_we_n = 1'b0; chk_bus = 1'b1; e_addr = last_wa; chk_wd = 1'b1; e_wdata = 32'h3333_0000;
    cyc();
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rstmid_sp", bus.sp, 32'h800);
    bus.mem_write = 1'b0; bus.push_en = 1'b0;
    #1;
    m_mem[last_wa] = 32'h3333_0000;
    m_sp = BASE; m_rd = 32'd0; m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e_ready = 1'b1; e_we_n = 1'b1; chk_bus = 1'b0; chk_wd = 1'b0;
    chk_en = 1'b1;
    idle(1);
    chk("rstmid_ready", 32'(bus.ready), 32'd1);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h4444_0000);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("rstmid_pop_rd", bus.rd_data, 32'h4444_0000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
